// File: rtl/terminal_text_writer_pkg.sv
// Shared constants, character codes and state encoding for the terminal text writer.
package terminal_text_writer_pkg;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [7:0] BLANK  = 8'h20;
  localparam logic [7:0] ASC_BS = 8'h08;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_FF = 8'h0C;
  localparam logic [7:0] ASC_CR = 8'h0D;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    ROW_CLR  = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/terminal_text_writer_if.sv
// Character input handshake plus buffer write and cursor/scroll publication.
interface terminal_text_writer_if;
  import terminal_text_writer_pkg::*;

  logic [7:0]        ascii_in;
  logic              ascii_valid;
  logic              ascii_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic [4:0]        scroll_base;

  modport master (
    output ascii_in, ascii_valid,
    input  ascii_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, scroll_base
  );

  modport slave (
    input  ascii_in, ascii_valid,
    output ascii_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, scroll_base
  );

endinterface

// File: rtl/terminal_text_writer_text_addr_calc.sv
// Maps (scroll_base, screen row, column) to a linear buffer address without a divider or multiplier.
module text_addr_calc
  import terminal_text_writer_pkg::*;
(
  input  logic [4:0]        scroll_base,
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] COLS_V = ADDR_W'(COLS);

  logic [5:0]        row_sum;
  logic [4:0]        phys_row;
  logic [ADDR_W-1:0] row_off;

  // Both operands are below ROWS, so one conditional subtract is enough for the modulo.
  always_comb begin
    row_sum = {1'b0, scroll_base} + {1'b0, row};
    if (row_sum >= 6'(ROWS)) begin
      phys_row = 5'(row_sum - 6'(ROWS));
    end else begin
      phys_row = row_sum[4:0];
    end
  end

  // Row times COLS built as a sum of shifted copies, one per set bit of COLS.
  always_comb begin
    row_off = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (COLS_V[i]) begin
        row_off = row_off + (ADDR_W'(phys_row) << i);
      end
    end
    addr = row_off + ADDR_W'(col);
  end

endmodule

// File: rtl/terminal_text_writer.sv
// Writes characters into the display buffer: printables, newline, backspace,
// form feed and hardware scroll, with full-screen and single-row blanking.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INIT_CLR | blank every cell 0..COLS*ROWS-1, one per cycle
// IDLE     | ready for one character; performs its write next cycle
// ROW_CLR  | blank the physical row that just became the bottom row
module terminal_text_writer
  import terminal_text_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  terminal_text_writer_if.slave tw
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [4:0]        clr_row_q, clr_row_d;
  logic [6:0]        cur_x_q, cur_x_d;
  logic [4:0]        cur_y_q, cur_y_d;
  logic [4:0]        scroll_q, scroll_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic [4:0]        calc_base;
  logic [4:0]        calc_row;
  logic [6:0]        calc_col;
  logic [ADDR_W-1:0] calc_addr;
  logic              newline;

  assign tw.ascii_ready = (state_q == IDLE);
  assign tw.wr_en       = wr_en_q;
  assign tw.wr_addr     = wr_addr_q;
  assign tw.wr_data     = wr_data_q;
  assign tw.cursor_x    = cur_x_q;
  assign tw.cursor_y    = cur_y_q;
  assign tw.scroll_base = scroll_q;

  // Single address calculator shared between the row clear and character writes.
  always_comb begin
    calc_base = scroll_q;
    calc_row  = cur_y_q;
    calc_col  = cur_x_q;
    if (state_q == ROW_CLR) begin
      calc_base = clr_row_q;
      calc_row  = '0;
      calc_col  = clr_cnt_q[6:0];
    end else if (tw.ascii_in == ASC_BS) begin
      calc_col = cur_x_q - 7'd1;
    end
  end

  text_addr_calc u_addr_calc (
    .scroll_base (calc_base),
    .row         (calc_row),
    .col         (calc_col),
    .addr        (calc_addr)
  );

  // Next-state, cursor and write-port logic; auto-wrap reuses the newline path.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_row_d = clr_row_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    scroll_d  = scroll_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    newline   = 1'b0;

    case (state_q)
      INIT_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = BLANK;
        if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      ROW_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = calc_addr;
        wr_data_d = BLANK;
        if (clr_cnt_q == ADDR_W'(COLS - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (tw.ascii_valid) begin
          if (is_printable(tw.ascii_in)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = calc_addr;
            wr_data_d = tw.ascii_in;
            if (cur_x_q < 7'(COLS - 1)) begin
              cur_x_d = cur_x_q + 7'd1;
            end else begin
              newline = 1'b1;
            end
          end else if ((tw.ascii_in == ASC_LF) || (tw.ascii_in == ASC_CR)) begin
            newline = 1'b1;
          end else if (tw.ascii_in == ASC_BS) begin
            if (cur_x_q != 7'd0) begin
              cur_x_d   = cur_x_q - 7'd1;
              wr_en_d   = 1'b1;
              wr_addr_d = calc_addr;
              wr_data_d = BLANK;
            end
          end else if (tw.ascii_in == ASC_FF) begin
            cur_x_d   = '0;
            cur_y_d   = '0;
            scroll_d  = '0;
            clr_cnt_d = '0;
            state_d   = INIT_CLR;
          end
        end
      end

      default: begin
        state_d   = INIT_CLR;
        clr_cnt_d = '0;
      end
    endcase

    // The old top row becomes the new bottom row after a scroll, so it is the one blanked.
    if (newline) begin
      cur_x_d = '0;
      if (cur_y_q < 5'(ROWS - 1)) begin
        cur_y_d = cur_y_q + 5'd1;
      end else begin
        scroll_d  = (scroll_q == 5'(ROWS - 1)) ? 5'd0 : scroll_q + 5'd1;
        clr_row_d = scroll_q;
        clr_cnt_d = '0;
        state_d   = ROW_CLR;
      end
    end
  end

  // State and output registers; reset restarts the full-screen clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= INIT_CLR;
      clr_cnt_q <= '0;
      clr_row_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      scroll_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clr_row_q <= clr_row_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      scroll_q  <= scroll_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
